conv_channel_accum_param: RTL and testbench

Parametrised channel-sum stage for the dilated-conv pipelines. It takes the serial stream of per-input-channel partial products from a 3x3 (dilated) convolution core and accumulates them across `CHANNEL_NUM_IN` channels into a full-image accumulator buffer. It then emits one finished, rounded and saturated pixel per output position. It generalises the fixed 2048-channel adder to arbitrary channel count, image size and accumulator width, and adds per-output-channel framing and overflow reporting.

---
 rtl/conv_channel_accum_param.sv | 85 ++++++++
 tb/tb_conv_channel_accum_param.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_channel_accum_param.sv
// conv_channel_accum_param: sums CHANNEL_NUM_IN partial-product planes into an image buffer, emits rounded/saturated pixels.
// Optional fused ReLU on the output when CONV_ACC_RELU_EN is defined.
module conv_channel_accum_param #(
  parameter int DATA_WIDTH      = 32,
  parameter int IMAGE_SIZE      = 23409,
  parameter int CHANNEL_NUM_IN  = 2048,
  parameter int CHANNEL_NUM_OUT = 256,
  parameter int ACC_WIDTH       = 48,
  parameter int FRAC_SHIFT      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  plane_done,
  output logic                  frame_done,
  output logic                  sat_flag
);
  localparam int PW = IMAGE_SIZE > 1 ? $clog2(IMAGE_SIZE) : 1;
  localparam int CW = CHANNEL_NUM_IN > 1 ? $clog2(CHANNEL_NUM_IN) : 1;
  localparam int OW = CHANNEL_NUM_OUT > 1 ? $clog2(CHANNEL_NUM_OUT) : 1;
  localparam logic signed [ACC_WIDTH:0] MAXV = {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV = {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH+1)'(1) << FRAC_SHIFT >> 1;
  localparam logic [DATA_WIDTH-1:0] MAXD = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIND = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic [PW-1:0] r_pix;
  logic [CW-1:0] r_ch;
  logic [OW-1:0] r_och;
  logic signed [ACC_WIDTH-1:0] r_acc [IMAGE_SIZE];
  logic signed [ACC_WIDTH-1:0] w_ext, w_sum;
  logic signed [ACC_WIDTH:0] w_rnd, w_shr;
  logic [DATA_WIDTH-1:0] w_clip, w_res;
  logic w_first, w_last, w_pix_end, w_och_end, w_hi, w_lo, w_emit;
  assign w_ext     = ACC_WIDTH'($signed(pxl_in));
  assign w_first   = r_ch == '0;
  assign w_last    = r_ch == CW'(CHANNEL_NUM_IN - 1);
  assign w_pix_end = r_pix == PW'(IMAGE_SIZE - 1);
  assign w_och_end = r_och == OW'(CHANNEL_NUM_OUT - 1);
  assign w_emit    = valid_in && w_last;
  assign w_sum     = CHANNEL_NUM_IN == 1 ? w_ext : r_acc[r_pix] + w_ext;
  // one guard bit keeps the rounding add from wrapping before the shift
  assign w_rnd  = {w_sum[ACC_WIDTH-1], w_sum} + RND;
  assign w_shr  = w_rnd >>> FRAC_SHIFT;
  assign w_hi   = w_shr > MAXV;
  assign w_lo   = w_shr < MINV;
  assign w_clip = w_hi ? MAXD : w_lo ? MIND : w_shr[DATA_WIDTH-1:0];
`ifdef CONV_ACC_RELU_EN
  assign w_res = w_clip[DATA_WIDTH-1] ? '0 : w_clip;
`else
  assign w_res = w_clip;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix      <= '0;
      r_ch       <= '0;
      r_och      <= '0;
      pxl_out    <= '0;
      valid_out  <= 1'b0;
      plane_done <= 1'b0;
      frame_done <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      valid_out  <= w_emit;
      plane_done <= w_emit && w_pix_end;
      frame_done <= w_emit && w_pix_end && w_och_end;
      if (w_emit) begin
        pxl_out  <= w_res;
        sat_flag <= sat_flag | w_hi | w_lo;
      end
      if (valid_in) begin
        r_pix <= w_pix_end ? '0 : r_pix + 1'b1;
        if (w_pix_end) begin
          r_ch <= w_last ? '0 : r_ch + 1'b1;
          if (w_last) r_och <= w_och_end ? '0 : r_och + 1'b1;
        end
      end
    end
  end
  // buffer holds no reset: the first channel overwrites every entry
  always_ff @(posedge clk)
    if (valid_in && !w_last) r_acc[r_pix] <= w_first ? w_ext : r_acc[r_pix] + w_ext;
endmodule

// File: tb/tb_conv_channel_accum_param.sv
// tb_conv_channel_accum_param: randomized self-checking bench over several parameterisations against an arithmetic model.
module tb_conv_channel_accum_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [4:0] rst, vi, vo, pd, fd, sf;
  logic [31:0] px [5];
  logic [31:0] po0, po1;
  logic [7:0]  po2;
  logic [15:0] po3, po4;
  int n = 0, err = 0;
  logic m_v[$], m_pd[$], m_fd[$], m_sf[$];
  logic signed [63:0] m_d[$];
  int m_spur;

  conv_channel_accum_param #(.DATA_WIDTH(32), .IMAGE_SIZE(4), .CHANNEL_NUM_IN(1), .CHANNEL_NUM_OUT(2), .ACC_WIDTH(48), .FRAC_SHIFT(0)) u_pt (
    .clk(clk), .reset(rst[0]), .valid_in(vi[0]), .pxl_in(px[0]), .pxl_out(po0),
    .valid_out(vo[0]), .plane_done(pd[0]), .frame_done(fd[0]), .sat_flag(sf[0]));
  conv_channel_accum_param #(.DATA_WIDTH(32), .IMAGE_SIZE(2), .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(2), .ACC_WIDTH(48), .FRAC_SHIFT(0)) u_acc (
    .clk(clk), .reset(rst[1]), .valid_in(vi[1]), .pxl_in(px[1]), .pxl_out(po1),
    .valid_out(vo[1]), .plane_done(pd[1]), .frame_done(fd[1]), .sat_flag(sf[1]));
  conv_channel_accum_param #(.DATA_WIDTH(8), .IMAGE_SIZE(2), .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(1), .ACC_WIDTH(16), .FRAC_SHIFT(0)) u_sat (
    .clk(clk), .reset(rst[2]), .valid_in(vi[2]), .pxl_in(px[2][7:0]), .pxl_out(po2),
    .valid_out(vo[2]), .plane_done(pd[2]), .frame_done(fd[2]), .sat_flag(sf[2]));
  conv_channel_accum_param #(.DATA_WIDTH(16), .IMAGE_SIZE(2), .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(1), .ACC_WIDTH(24), .FRAC_SHIFT(2)) u_rnd (
    .clk(clk), .reset(rst[3]), .valid_in(vi[3]), .pxl_in(px[3][15:0]), .pxl_out(po3),
    .valid_out(vo[3]), .plane_done(pd[3]), .frame_done(fd[3]), .sat_flag(sf[3]));
  conv_channel_accum_param #(.DATA_WIDTH(16), .IMAGE_SIZE(3), .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2), .ACC_WIDTH(24), .FRAC_SHIFT(0)) u_frm (
    .clk(clk), .reset(rst[4]), .valid_in(vi[4]), .pxl_in(px[4][15:0]), .pxl_out(po4),
    .valid_out(vo[4]), .plane_done(pd[4]), .frame_done(fd[4]), .sat_flag(sf[4]));

  function automatic logic signed [63:0] pos(input int u);
    return u == 0 ? 64'(signed'(po0)) : u == 1 ? 64'(signed'(po1)) : u == 2 ? 64'(signed'(po2)) :
           u == 3 ? 64'(signed'(po3)) : 64'(signed'(po4));
  endfunction

  // expected pixel from an exact channel sum: round half up, shift, clamp, optional ReLU
  function automatic longint mdl(input longint s, input int dw, input int fs, output bit clip);
    longint r, mx, mn;
    r = fs > 0 ? (s + (longint'(1) << (fs - 1))) >>> fs : s;
    mx = (longint'(1) << (dw - 1)) - 1;
    mn = -mx - 1;
    clip = r > mx || r < mn;
    r = r > mx ? mx : r < mn ? mn : r;
`ifdef CONV_ACC_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  // streams q into instance u with random idle gaps; records outputs one cycle after each sample
  task automatic drive(input int u, input int q[$], input int gap);
    m_v.delete(); m_d.delete(); m_pd.delete(); m_fd.delete(); m_sf.delete();
    m_spur = 0;
    @(negedge clk);
    foreach (q[k]) begin
      while (int'($urandom_range(0, 99)) < gap) begin
        vi[u] = 1'b0;
        @(negedge clk);
        if (vo[u] !== 1'b0) m_spur++;
      end
      vi[u] = 1'b1;
      px[u] = q[k];
      @(negedge clk);
      m_v.push_back(vo[u]); m_d.push_back(pos(u)); m_pd.push_back(pd[u]); m_fd.push_back(fd[u]); m_sf.push_back(sf[u]);
    end
    vi[u] = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rst = '0;
    for (int u = 0; u < 5; u++) begin
      n++;
      if (vo[u] !== 1'b0 || pd[u] !== 1'b0 || fd[u] !== 1'b0 || sf[u] !== 1'b0 || pos(u) !== 64'sd0) begin
        err++;
        $display("FAIL reset u=%0d got v=%b pd=%b fd=%b sf=%b d=%0d want all 0", u, vo[u], pd[u], fd[u], sf[u], pos(u));
      end
    end
  endtask

  task automatic test_pass_through;
    int q[$];
    longint ed;
    logic es = 1'b0;
    bit c;
    q = '{5, -3, 7, 0};
    repeat (4) q.push_back(int'($urandom));
    drive(0, q, 0);
    foreach (q[k]) begin
      ed = mdl(longint'(q[k]), 32, 0, c);
      es |= c;
      n++;
      if (m_v[k] !== 1'b1 || m_d[k] !== ed || m_pd[k] !== (k % 4 == 3) || m_fd[k] !== (k == 7) || m_sf[k] !== es) begin
        err++;
        $display("FAIL pass k=%0d got v=%b d=%0d pd=%b fd=%b sf=%b want v=1 d=%0d pd=%b fd=%b sf=%b",
                 k, m_v[k], m_d[k], m_pd[k], m_fd[k], m_sf[k], ed, k % 4 == 3, k == 7, es);
      end
    end
    @(negedge clk);
    n++;
    if (vo[0] !== 1'b0 || pos(0) !== ed) begin
      err++;
      $display("FAIL hold got v=%b d=%0d want v=0 d=%0d", vo[0], pos(0), ed);
    end
  endtask

  task automatic test_accumulate;
    int d[2][3][2];
    int q[$];
    int o, ch, p;
    longint ed;
    logic es = 1'b0, v, epd, efd;
    bit c;
    d[0] = '{'{1, 2}, '{10, 20}, '{100, 200}};
    for (int i = 0; i < 3; i++) for (int j = 0; j < 2; j++) d[1][i][j] = int'($urandom_range(0, 200000)) - 100000;
    for (int h = 0; h < 2; h++) for (int i = 0; i < 3; i++) for (int j = 0; j < 2; j++) q.push_back(d[h][i][j]);
    drive(1, q, 40);
    foreach (q[k]) begin
      o = k / 6; ch = (k / 2) % 3; p = k % 2;
      v = ch == 2;
      ed = mdl(longint'(d[o][0][p]) + d[o][1][p] + d[o][2][p], 32, 0, c);
      if (v) es |= c;
      epd = v && p == 1;
      efd = epd && o == 1;
      n++;
      if (m_v[k] !== v || m_pd[k] !== epd || m_fd[k] !== efd || m_sf[k] !== es || (v && m_d[k] !== ed)) begin
        err++;
        $display("FAIL accum k=%0d got v=%b d=%0d pd=%b fd=%b sf=%b want v=%b d=%0d pd=%b fd=%b sf=%b",
                 k, m_v[k], m_d[k], m_pd[k], m_fd[k], m_sf[k], v, ed, epd, efd, es);
      end
    end
    n++;
    if (m_spur != 0) begin err++; $display("FAIL accum_idle got %0d stray valid_out want 0", m_spur); end
  endtask

  task automatic test_saturation;
    int d[4][2][2];
    int q[$];
    int f, ch, p;
    longint ed;
    logic es = 1'b0, v, epd;
    bit c;
    d[0] = '{'{100, -100}, '{100, -100}};
    for (int h = 1; h < 4; h++) for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) d[h][i][j] = int'($urandom_range(0, 255)) - 128;
    for (int h = 0; h < 4; h++) for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) q.push_back(d[h][i][j]);
    drive(2, q, 20);
    foreach (q[k]) begin
      f = k / 4; ch = (k / 2) % 2; p = k % 2;
      v = ch == 1;
      ed = mdl(longint'(d[f][0][p]) + d[f][1][p], 8, 0, c);
      if (v) es |= c;
      epd = v && p == 1;
      n++;
      if (m_v[k] !== v || m_pd[k] !== epd || m_fd[k] !== epd || m_sf[k] !== es || (v && m_d[k] !== ed)) begin
        err++;
        $display("FAIL sat k=%0d got v=%b d=%0d pd=%b fd=%b sf=%b want v=%b d=%0d pd=%b fd=%b sf=%b",
                 k, m_v[k], m_d[k], m_pd[k], m_fd[k], m_sf[k], v, ed, epd, epd, es);
      end
    end
    n++;
    if (m_spur != 0) begin err++; $display("FAIL sat_idle got %0d stray valid_out want 0", m_spur); end
  endtask

  task automatic test_rounding;
    int d[4][2][2];
    int q[$];
    int f, ch, p;
    longint ed;
    logic es = 1'b0, v, epd;
    bit c;
    d[0] = '{'{3, -2}, '{3, -4}};
    for (int h = 1; h < 4; h++) for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) d[h][i][j] = int'($urandom_range(0, 65535)) - 32768;
    for (int h = 0; h < 4; h++) for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) q.push_back(d[h][i][j]);
    drive(3, q, 30);
    foreach (q[k]) begin
      f = k / 4; ch = (k / 2) % 2; p = k % 2;
      v = ch == 1;
      ed = mdl(longint'(d[f][0][p]) + d[f][1][p], 16, 2, c);
      if (v) es |= c;
      epd = v && p == 1;
      n++;
      if (m_v[k] !== v || m_pd[k] !== epd || m_fd[k] !== epd || m_sf[k] !== es || (v && m_d[k] !== ed)) begin
        err++;
        $display("FAIL round k=%0d got v=%b d=%0d pd=%b fd=%b sf=%b want v=%b d=%0d pd=%b fd=%b sf=%b",
                 k, m_v[k], m_d[k], m_pd[k], m_fd[k], m_sf[k], v, ed, epd, epd, es);
      end
    end
  endtask

  task automatic test_frame_reset;
    int d[12];
    int q[$], j[$];
    int kk, o, ch, p;
    longint ed;
    logic es = 1'b0, v, epd, efd;
    bit c;
    repeat (4) j.push_back(int'($urandom_range(0, 65535)) - 32768);
    drive(4, j, 0);
    rst[4] = 1'b1;
    @(negedge clk);
    rst[4] = 1'b0;
    n++;
    if (vo[4] !== 1'b0 || pd[4] !== 1'b0 || fd[4] !== 1'b0 || sf[4] !== 1'b0 || pos(4) !== 64'sd0) begin
      err++;
      $display("FAIL mid_reset got v=%b pd=%b fd=%b sf=%b d=%0d want all 0", vo[4], pd[4], fd[4], sf[4], pos(4));
    end
    foreach (d[i]) d[i] = int'($urandom_range(0, 40000)) - 20000;
    repeat (2) foreach (d[i]) q.push_back(d[i]);
    drive(4, q, 25);
    foreach (q[k]) begin
      kk = k % 12; o = kk / 6; ch = (kk / 3) % 2; p = kk % 3;
      v = ch == 1;
      ed = mdl(longint'(d[o * 6 + p]) + d[o * 6 + 3 + p], 16, 0, c);
      if (v) es |= c;
      epd = v && p == 2;
      efd = epd && o == 1;
      n++;
      if (m_v[k] !== v || m_pd[k] !== epd || m_fd[k] !== efd || m_sf[k] !== es || (v && m_d[k] !== ed)) begin
        err++;
        $display("FAIL frame k=%0d got v=%b d=%0d pd=%b fd=%b sf=%b want v=%b d=%0d pd=%b fd=%b sf=%b",
                 k, m_v[k], m_d[k], m_pd[k], m_fd[k], m_sf[k], v, ed, epd, efd, es);
      end
    end
    n++;
    if (m_spur != 0) begin err++; $display("FAIL frame_idle got %0d stray valid_out want 0", m_spur); end
  endtask

  initial begin
    rst = '1;
    vi = '0;
    foreach (px[i]) px[i] = '0;
    test_reset;
    test_pass_through;
    test_accumulate;
    test_saturation;
    test_rounding;
    test_frame_reset;
    $display("Result: errors=%0d of %0d checks", err, n);
    $finish;
  end
endmodule
